// File: rtl/inst_fetcher.sv
// Instruction supply for the decoder: direct-mapped halfword-indexed I-cache
// backed by a serial byte fetch that recognises RV32C encodings on the fly.
module inst_fetcher #(
    parameter int ICACHE_IDX_W = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        if_enable,
    input  logic [31:0] if_addr,
    output logic        inst_ready,
    output logic        is_c,
    output logic [31:0] inst_val,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_data
);

    localparam int ENTRIES = 1 << ICACHE_IDX_W;
    localparam int TAG_W   = 31 - ICACHE_IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t                    state, state_nxt;
    logic [1:0]                cnt, cnt_nxt;
    logic [31:0]               fetch_pc, pc_nxt;
    logic [31:0]               fetch_buf, buf_nxt;
    logic                      ready_nxt, c_nxt, req_nxt;
    logic [31:0]               val_nxt, addr_nxt;

    logic [ENTRIES-1:0]        valid_q;
    logic [TAG_W-1:0]          tag_q  [ENTRIES];
    logic [31:0]               data_q [ENTRIES];

    logic [ICACHE_IDX_W-1:0]   hit_idx, fill_idx;
    logic                      hit;
    logic [31:0]               hit_data;
    logic                      fill_en, fill_c;
    logic [31:0]               fill_data;

    assign hit_idx  = if_addr[ICACHE_IDX_W:1];
    assign fill_idx = fetch_pc[ICACHE_IDX_W:1];
    assign hit_data = data_q[hit_idx];
    assign hit      = valid_q[hit_idx] && (tag_q[hit_idx] == if_addr[31:ICACHE_IDX_W+1]);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_nxt    = fetch_pc;
        buf_nxt   = fetch_buf;
        ready_nxt = 1'b0;
        val_nxt   = inst_val;
        c_nxt     = is_c;
        req_nxt   = mem_req;
        addr_nxt  = mem_addr;
        fill_en   = 1'b0;
        fill_c    = 1'b0;
        fill_data = 32'h0;
        if (clear) begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_enable) begin
                        if (hit) begin
                            ready_nxt = 1'b1;
                            val_nxt   = hit_data;
                            c_nxt     = (hit_data[1:0] != 2'b11);
                        end else begin
                            pc_nxt    = if_addr;
                            cnt_nxt   = 2'd0;
                            state_nxt = FETCH;
                            req_nxt   = 1'b1;
                            addr_nxt  = if_addr;
                        end
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        buf_nxt[{cnt, 3'b000} +: 8] = mem_data;
                        cnt_nxt  = cnt + 2'd1;
                        addr_nxt = mem_addr + 32'd1;
                        fill_c   = (buf_nxt[1:0] != 2'b11);
                        // Length is known once the first halfword is in.
                        if ((cnt == 2'd1 && fill_c) || cnt == 2'd3) begin
                            fill_en   = 1'b1;
                            fill_data = fill_c ? {16'h0, buf_nxt[15:0]} : buf_nxt;
                            state_nxt = IDLE;
                            req_nxt   = 1'b0;
                            if (if_addr == fetch_pc) begin
                                ready_nxt = 1'b1;
                                val_nxt   = fill_data;
                                c_nxt     = fill_c;
                            end
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            valid_q    <= '0;
            inst_ready <= 1'b0;
            is_c       <= 1'b0;
            inst_val   <= 32'h0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'h0;
        end else if (rdy_in) begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            inst_ready <= ready_nxt;
            is_c       <= c_nxt;
            inst_val   <= val_nxt;
            mem_req    <= req_nxt;
            mem_addr   <= addr_nxt;
            if (fill_en)
                valid_q[fill_idx] <= 1'b1;
        end
    end

    // Datapath storage; validity is tracked by valid_q alone.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !rst_in) begin
            fetch_pc  <= pc_nxt;
            fetch_buf <= buf_nxt;
            if (fill_en) begin
                tag_q[fill_idx]  <= fetch_pc[31:ICACHE_IDX_W+1];
                data_q[fill_idx] <= fill_data;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: table of fetch requests against a byte
// memory model, plus hand sequences for clear, rdy_in stall and redirect.
module tb_inst_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, if_enable;
    logic [31:0] if_addr;
    logic        inst_ready, is_c;
    logic [31:0] inst_val;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_data;

    logic [7:0]  mem [256];
    logic        resp_en;
    logic [31:0] addr_log [$];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          nload;
        logic [31:0] exp_val;
        logic        exp_c;
        int          exp_lat;
        int          exp_reads;
    } vec_t;

    vec_t vecs [12];

    inst_fetcher #(.ICACHE_IDX_W(6)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .clear     (clear),
        .if_enable (if_enable),
        .if_addr   (if_addr),
        .inst_ready(inst_ready),
        .is_c      (is_c),
        .inst_val  (inst_val),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_data  (mem_data)
    );

    always #5 clk_in = ~clk_in;

    assign mem_ready = mem_req & resp_en;
    assign mem_data  = mem[mem_addr[7:0]];

    // Bytes the DUT actually accepts.
    always @(posedge clk_in)
        if (!rst_in && rdy_in && !clear && mem_req && mem_ready)
            addr_log.push_back(mem_addr);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [31:0] addr, input logic [31:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = addr + 32'(i);
            mem[a[7:0]] = word[8*i +: 8];
        end
    endtask

    task automatic wait_ready(input int maxc, output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        for (int k = 0; k < maxc && !got; k++) begin
            @(negedge clk_in);
            cyc = k + 1;
            got = inst_ready;
        end
    endtask

    task automatic wait_reads(input int n, input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk_in);
            ok = (addr_log.size() == n);
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic do_request(input vec_t v, input string name);
        int cyc;
        bit got;
        if (v.nload > 0)
            load_mem(v.addr, v.word, v.nload);
        addr_log.delete();
        if_addr   = v.addr;
        if_enable = 1'b1;
        wait_ready(20, cyc, got);
        check({name, "_got"},   32'(got), 32'd1);
        check({name, "_lat"},   32'(cyc), 32'(v.exp_lat));
        check({name, "_val"},   inst_val, v.exp_val);
        check({name, "_isc"},   32'(is_c), 32'(v.exp_c));
        check({name, "_reads"}, 32'(addr_log.size()), 32'(v.exp_reads));
        if (v.exp_reads > 0 && addr_log.size() > 0) begin
            check({name, "_first"}, addr_log[0], v.addr);
            check({name, "_last"},  addr_log[addr_log.size()-1], v.addr + 32'(v.exp_reads) - 32'd1);
        end
        if_enable = 1'b0;
        @(negedge clk_in);
        check({name, "_single"}, 32'(inst_ready), 32'd0);
        check({name, "_noreq"},  32'(mem_req), 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  got;

        // addr, word loaded, nload, expected val, is_c, latency, byte reads
        vecs[0]  = '{32'h0000_0000, 32'h0010_0513, 4, 32'h0010_0513, 1'b0, 5, 4};
        vecs[1]  = '{32'h0000_0000, 32'h0,         0, 32'h0010_0513, 1'b0, 1, 0};
        vecs[2]  = '{32'h0000_0006, 32'h0000_4505, 2, 32'h0000_4505, 1'b1, 3, 2};
        vecs[3]  = '{32'h0000_0006, 32'h0,         0, 32'h0000_4505, 1'b1, 1, 0};
        vecs[4]  = '{32'h0000_0002, 32'h00a0_0593, 4, 32'h00a0_0593, 1'b0, 5, 4};
        vecs[5]  = '{32'h0000_0002, 32'h0,         0, 32'h00a0_0593, 1'b0, 1, 0};
        vecs[6]  = '{32'h0000_0000, 32'h0,         0, 32'h0010_0513, 1'b0, 1, 0};
        vecs[7]  = '{32'h0000_0086, 32'h0000_0001, 2, 32'h0000_0001, 1'b1, 3, 2};
        vecs[8]  = '{32'h0000_0006, 32'h0,         0, 32'h0000_4505, 1'b1, 3, 2};
        vecs[9]  = '{32'h0000_0086, 32'h0,         0, 32'h0000_0001, 1'b1, 3, 2};
        vecs[10] = '{32'hFFFF_FFFE, 32'h0513_0093, 4, 32'h0513_0093, 1'b0, 5, 4};
        vecs[11] = '{32'hFFFF_FFFE, 32'h0,         0, 32'h0513_0093, 1'b0, 1, 0};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; if_enable = 1'b0;
        if_addr = 32'h0; resp_en = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rst_inst_ready", 32'(inst_ready), 32'd0);
        check("rst_is_c",       32'(is_c), 32'd0);
        check("rst_inst_val",   inst_val, 32'h0);
        check("rst_mem_req",    32'(mem_req), 32'd0);
        check("rst_mem_addr",   mem_addr, 32'h0);
        rst_in = 1'b0;
        @(negedge clk_in);

        for (int i = 0; i < 12; i++)
            do_request(vecs[i], $sformatf("vec%0d", i));

        // Decoder stalls and keeps re-requesting a cached PC.
        if_addr = 32'h2; if_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            check($sformatf("redeliver%0d_rdy", k), 32'(inst_ready), 32'd1);
            check($sformatf("redeliver%0d_val", k), inst_val, 32'h00a0_0593);
        end
        if_enable = 1'b0;
        @(negedge clk_in);

        // Clear after the second byte: no fill, no delivery.
        load_mem(32'h10, 32'h0000_0013, 4);
        addr_log.delete();
        if_addr = 32'h10; if_enable = 1'b1;
        wait_reads(2, "clr_two_bytes");
        clear = 1'b1; if_enable = 1'b0;
        @(negedge clk_in);
        clear = 1'b0;
        check("clr_mem_req",  32'(mem_req), 32'd0);
        check("clr_no_rdy",   32'(inst_ready), 32'd0);
        check("clr_reads",    32'(addr_log.size()), 32'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            check($sformatf("clr_quiet%0d", k), 32'({inst_ready, mem_req}), 32'd0);
        end
        do_request('{32'h10, 32'h0, 0, 32'h0000_0013, 1'b0, 5, 4}, "clr_refetch");

        // rdy_in low mid-fetch while mem_ready toggles.
        load_mem(32'h20, 32'h00c0_0613, 4);
        addr_log.delete();
        if_addr = 32'h20; if_enable = 1'b1;
        wait_reads(2, "stall_two_bytes");
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            resp_en = ~resp_en;
            @(negedge clk_in);
            check($sformatf("stall%0d_addr", k),  mem_addr, 32'h22);
            check($sformatf("stall%0d_req", k),   32'(mem_req), 32'd1);
            check($sformatf("stall%0d_reads", k), 32'(addr_log.size()), 32'd2);
        end
        rdy_in = 1'b1; resp_en = 1'b1;
        wait_ready(10, cyc, got);
        check("stall_got",   32'(got), 32'd1);
        check("stall_lat",   32'(cyc), 32'd2);
        check("stall_val",   inst_val, 32'h00c0_0613);
        check("stall_isc",   32'(is_c), 32'd0);
        check("stall_reads", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4)
            check("stall_last", addr_log[3], 32'h23);
        if_enable = 1'b0;
        @(negedge clk_in);

        // PC moves away during a fetch: fill completes silently, new PC hits.
        load_mem(32'h40, 32'h0000_0013, 4);
        addr_log.delete();
        if_addr = 32'h40; if_enable = 1'b1;
        @(negedge clk_in);
        check("redir_fetching", 32'(mem_req), 32'd1);
        if_addr = 32'h0;
        wait_ready(15, cyc, got);
        check("redir_got",   32'(got), 32'd1);
        check("redir_lat",   32'(cyc + 1), 32'd6);
        check("redir_val",   inst_val, 32'h0010_0513);
        check("redir_reads", 32'(addr_log.size()), 32'd4);
        if_enable = 1'b0;
        @(negedge clk_in);
        do_request('{32'h40, 32'h0, 0, 32'h0000_0013, 1'b0, 1, 0}, "redir_filled");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Instruction-supply end of the fetch interface. Answers the decoder's if_enable/if_addr requests with inst_ready/inst_val/is_c.
- Keeps a direct-mapped instruction cache indexed by halfword address.
- On a miss, reads bytes serially from the memory controller's fetch port and detects RV32C compressed encodings from the first halfword.

Parameters:
- ICACHE_IDX_W, 6: index width; the cache has 2^ICACHE_IDX_W entries, indexed by addr[ICACHE_IDX_W:1].

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; when low, all state is frozen
- clear  input  1  misprediction flush; aborts any fetch
- if_enable  input  1  decoder requests the instruction at if_addr
- if_addr  input  32  requested PC, halfword aligned
- inst_ready  output  1  one-cycle pulse: inst_val/is_c are valid for the PC the decoder holds
- is_c  output  1  delivered instruction is 16-bit compressed
- inst_val  output  32  raw instruction; upper 16 bits are zero when is_c
- mem_req  output  1  byte-read request to the memory controller
- mem_addr  output  32  byte address being requested
- mem_ready  input  1  mem_data holds the byte at mem_addr this cycle
- mem_data  input  8  returned byte

Behaviour:
- Reset:
  - Invalidate all cache valid bits; state=IDLE.
  - inst_ready=0, is_c=0, inst_val=0, mem_req=0, mem_addr=0.
- rdy_in low (and not reset): no register changes; mem_ready is ignored.
- Cache entry: valid, tag=addr[31:ICACHE_IDX_W+1], data[31:0]. Compressed iff data[1:0]!=2'b11.
- Cache contents survive clear. Instruction memory is read-only, so there is no invalidate other than reset.
- inst_ready defaults to 0 every cycle unless a delivery is scheduled below.
- IDLE:
  - If clear: stay IDLE.
  - Else if if_enable and hit(if_addr): next cycle inst_ready=1, inst_val=data (upper half zeroed if compressed), is_c=(data[1:0]!=3).
  - Hit latency is 1 cycle. Back-to-back hits deliver every cycle, because the decoder changes if_addr in the same cycle as the pulse.
  - Else if if_enable and miss: latch fetch_pc=if_addr, cnt=0. Next cycle go to FETCH with mem_req=1, mem_addr=if_addr.
- FETCH:
  - mem_req stays high. On each mem_ready, store mem_data into byte cnt of the buffer, then cnt+=1 and mem_addr+=1.
  - After byte 1, if buffer[1:0]!=2'b11: done (2 bytes). Otherwise continue to byte 3: done (4 bytes).
  - Done edge:
    - Write the cache entry at fetch_pc, with upper 16 bits zero for compressed.
    - Drop mem_req; return to IDLE.
    - Next cycle, inst_ready=1 only if if_addr==fetch_pc at the done edge; otherwise fill only.
  - if_enable and if_addr changes during FETCH do not abort or redirect the fetch.
- Redelivery: a pulse that the decoder does not consume (its stall conditions are high) is simply re-requested. The next lookup hits.
- clear (any state, rdy_in high):
  - Takes priority over hit, miss and mem_ready in that cycle.
  - Next cycle: state=IDLE, mem_req=0, inst_ready=0.
  - Partial bytes are discarded and the cache is not written.
  - The memory controller must tolerate mem_req dropping mid-transfer; a mem_ready in the clear cycle is ignored.
- mem_ready while mem_req=0 is ignored.
- Arithmetic:
  - mem_addr increments mod 2^32.
  - Instructions may straddle 4-byte boundaries; no alignment beyond bit 0 is assumed.
  - if_addr[0] is ignored for indexing.
- No delivery occurs in the same cycle as a clear, or in the cycle following one.

Test Plan:
- Reset, then if_enable=1, if_addr=0x0, memory bytes 13 05 10 00 (addi a0,x0,1):
  - mem_req high with mem_addr 0,1,2,3.
  - One cycle after the 4th mem_ready: inst_ready=1, inst_val=0x00100513, is_c=0.
- Re-request 0x0 after the fill: inst_ready exactly 1 cycle after if_enable, with the same value and no mem_req.
- if_addr=0x6, bytes 05 45 (c.li a0,1):
  - Exactly 2 byte reads (addresses 6,7).
  - inst_val=0x00004505, is_c=1.
  - A later fetch at 0x6 hits.
- Miss at 0x10, clear pulsed after 2nd mem_ready:
  - mem_req=0 next cycle; no inst_ready.
  - A subsequent if_addr=0x10 misses again and performs a full 4-byte read.
- Straddle and redelivery:
  - 32-bit instruction at 0x2 (bytes at 2..5) delivers correctly with the cache indexed by 0x2.
  - The decoder holding if_addr (not consuming) gets repeated 1-cycle hit pulses.
- rdy_in low for 3 cycles mid-FETCH with mem_ready toggling: cnt and mem_addr are unchanged. The fetch resumes and completes correctly once rdy_in returns high.
